cdb_arbiter: RTL and testbench

//  Shares the single common data bus (CDB) between NUM_REQ functional-unit result ports.

---
 rtl/cdb_arbiter.sv | 76 +++++++
 tb/tb_cdb_arbiter.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter that picks one functional-unit result per cycle and
// registers it onto the common data bus one cycle later.
module cdb_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 32,
  parameter int TAG_W   = 4,
  parameter int NAME_W  = 5,
  localparam int SRC_W  = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*NAME_W-1:0] req_name,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  input  logic [NUM_REQ*TAG_W-1:0]  req_tag,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      cdb_en,
  output logic [NAME_W-1:0]         cdb_name,
  output logic [DATA_W-1:0]         cdb_data,
  output logic [TAG_W-1:0]          cdb_tag,
  output logic [SRC_W-1:0]          cdb_src
);

  logic [NUM_REQ-1:0][NAME_W-1:0] name_a;
  logic [NUM_REQ-1:0][DATA_W-1:0] data_a;
  logic [NUM_REQ-1:0][TAG_W-1:0]  tag_a;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign name_a[i] = req_name[i*NAME_W +: NAME_W];
    assign data_a[i] = req_data[i*DATA_W +: DATA_W];
    assign tag_a[i]  = req_tag[i*TAG_W +: TAG_W];
  end

  logic [SRC_W-1:0] ptr;
  logic [SRC_W-1:0] gidx;
  logic             found;

  // Scan from ptr upward with wrap; first valid requester wins.
  always_comb begin
    found = 1'b0;
    gidx  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!found && req_valid[(int'(ptr) + k) % NUM_REQ]) begin
        found = 1'b1;
        gidx  = SRC_W'((int'(ptr) + k) % NUM_REQ);
      end
    end
    if (rst || flush) found = 1'b0;
    req_ready = '0;
    if (found) req_ready[gidx] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr      <= '0;
      cdb_en   <= 1'b0;
      cdb_name <= '0;
      cdb_data <= '0;
      cdb_tag  <= '0;
      cdb_src  <= '0;
    end else begin
      cdb_en <= 1'b0;
      if (found) begin
        ptr      <= (gidx == SRC_W'(NUM_REQ-1)) ? '0 : gidx + SRC_W'(1);
        // Tag 0 is not a producer: consume the result but suppress the wakeup.
        cdb_en   <= (tag_a[gidx] != '0);
        cdb_name <= name_a[gidx];
        cdb_data <= data_a[gidx];
        cdb_tag  <= tag_a[gidx];
        cdb_src  <= gidx;
      end
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: directed scenarios then random traffic, compared
// against a cycle-level behavioural model of the arbitration rules.
module tb_cdb_arbiter;
  localparam int N = 4;

  logic        clk, rst, flush;
  logic [3:0]  req_valid, req_ready;
  logic [19:0] req_name;
  logic [127:0] req_data;
  logic [15:0] req_tag;
  logic        cdb_en;
  logic [4:0]  cdb_name;
  logic [31:0] cdb_data;
  logic [3:0]  cdb_tag;
  logic [1:0]  cdb_src;

  logic [4:0]  rn [N];
  logic [31:0] rd [N];
  logic [3:0]  rt [N];

  int checks = 0;
  int errors = 0;

  // model state
  int          mptr;
  bit          mvalid, mfld, men;
  logic [4:0]  mname;
  logic [31:0] mdata;
  logic [3:0]  mtag;
  int          msrc;

  cdb_arbiter dut (
    .clk(clk), .rst(rst), .flush(flush),
    .req_valid(req_valid), .req_name(req_name), .req_data(req_data), .req_tag(req_tag),
    .req_ready(req_ready), .cdb_en(cdb_en), .cdb_name(cdb_name), .cdb_data(cdb_data),
    .cdb_tag(cdb_tag), .cdb_src(cdb_src)
  );

  always #5 clk = ~clk;

  always_comb begin
    req_name = '0;
    req_data = '0;
    req_tag  = '0;
    for (int i = 0; i < N; i++) begin
      req_name[i*5 +: 5]   = rn[i];
      req_data[i*32 +: 32] = rd[i];
      req_tag[i*4 +: 4]    = rt[i];
    end
  end

  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h at %0t", nm, got, exp, $time);
    end
  endtask

  function automatic int mgrant();
    if (rst || flush) return -1;
    for (int k = 0; k < N; k++)
      if (req_valid[(mptr + k) % N]) return (mptr + k) % N;
    return -1;
  endfunction

  // One cycle: drive at negedge, check just after, advance model at posedge.
  task automatic step(input logic [3:0] v, input logic f, input logic r);
    int g;
    logic [3:0] er;
    req_valid = v; flush = f; rst = r;
    #1;
    g  = mgrant();
    er = (g >= 0) ? 4'(1 << g) : 4'b0;
    check("ready", req_ready, er);
    if (mvalid) begin
      check("cdb_en", cdb_en, men);
      if (mfld) begin
        check("cdb_name", cdb_name, mname);
        check("cdb_data", cdb_data, mdata);
        check("cdb_tag",  cdb_tag,  mtag);
        check("cdb_src",  cdb_src,  msrc);
      end
    end
    @(posedge clk);
    if (r) begin
      mptr = 0; men = 0; mname = 0; mdata = 0; mtag = 0; msrc = 0;
      mvalid = 1; mfld = 1;
    end else if (g >= 0) begin
      mptr  = (g + 1) % N;
      men   = (rt[g] != 0);
      mname = rn[g]; mdata = rd[g]; mtag = rt[g]; msrc = g;
      mfld  = men;
    end else begin
      men = 0;
    end
    @(negedge clk);
  endtask

  initial begin
    clk = 0; rst = 1; flush = 0; req_valid = 0;
    mvalid = 0; mfld = 0; men = 0; mptr = 0;
    mname = 0; mdata = 0; mtag = 0; msrc = 0;
    for (int i = 0; i < N; i++) begin
      rn[i] = 5'(i + 1); rd[i] = 32'h1000 + i; rt[i] = 4'(i + 1);
    end
    @(negedge clk);

    // reset with all requesting, then first grant at index 0
    step(4'b1111, 0, 1);
    step(4'b1111, 0, 1);
    step(4'b1111, 0, 0);

    // single request on index 2
    step(4'b0000, 0, 1);
    rn[2] = 5'd7; rd[2] = 32'hDEAD_BEEF; rt[2] = 4'd3;
    step(4'b0100, 0, 0);
    step(4'b0000, 0, 0);

    // full round-robin rotation
    step(4'b0000, 0, 1);
    repeat (8) step(4'b1111, 0, 0);
    step(4'b0000, 0, 0);

    // wrap and skip from ptr=3
    step(4'b0100, 0, 0);
    step(4'b0011, 0, 0);
    step(4'b0010, 0, 0);
    step(4'b0000, 0, 0);
    step(4'b0000, 0, 0);

    // flush blocks grant and holds ptr
    step(4'b1010, 1, 0);
    step(4'b1010, 0, 0);
    step(4'b0000, 0, 0);

    // tag 0 consumed without wakeup; reset right after a grant
    rt[1] = 4'd0;
    step(4'b0010, 0, 0);
    step(4'b0000, 0, 0);
    step(4'b0001, 0, 0);
    step(4'b1111, 0, 1);
    step(4'b1111, 0, 0);

    // random traffic
    repeat (400) begin
      for (int i = 0; i < N; i++) begin
        rn[i] = 5'($urandom);
        rd[i] = $urandom;
        rt[i] = ($urandom_range(0, 5) == 0) ? 4'd0 : 4'($urandom);
      end
      step(4'($urandom), ($urandom_range(0, 7) == 0), ($urandom_range(0, 39) == 0));
    end
    step(4'b0000, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
